// File: rtl/data_mem_arbiter.sv
// Purpose: round-robin arbiter giving two requesters (CPU, debug/DMA) serialized access to one data memory.
// Latency: request sampled at edge N, gnt in cycle N+1 (memory access), rvalid in cycle N+2; one access per 3 cycles.
// Backpressure: a requester holds req and its inputs until its gnt; the loser simply waits in the next IDLE cycle.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req*/we*/rd_type*/addr*/wdata* per-port request (rd_type: 1 word, 2 signed half, 3 unsigned half, 0 none)
//   gnt*/rvalid*/rdata*            per-port accept pulse, completion pulse, held read result
//   mem_address/mem_write_data/mem_write/mem_read/mem_data_out  data-memory side (combinational read data)
module data_mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  rd_type0,
  input  logic [1:0]  rd_type1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic [1:0]  mem_read,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        cur_port;
  logic        accept;
  logic        win_port;
  logic        lat_we;
  logic [1:0]  lat_rd_type;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rd_capture;

  // State register. Every output below is decoded from registered state, so
  // reset clears them asynchronously (an in-flight write drops mem_write at once).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    win_port       = 1'b0;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    rvalid0        = 1'b0;
    rvalid1        = 1'b0;
    mem_address    = 32'h0;
    mem_write_data = 32'h0;
    mem_write      = 1'b0;
    mem_read       = 2'd0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept    = 1'b1;
          // On a tie the port that did not win last time goes next.
          win_port  = (req0 && req1) ? ~last_grant : req1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        gnt0      = ~cur_port;
        gnt1      = cur_port;
        state_nxt = DONE;
        if (lat_we) begin
          mem_address    = lat_addr;
          mem_write_data = lat_wdata;
          mem_write      = 1'b1;
        end else if (lat_rd_type != 2'd0) begin
          mem_address = lat_addr;
          mem_read    = lat_rd_type;
        end
        // A read with rd_type 0 leaves the memory bus idle.
      end
      DONE: begin
        rvalid0   = ~cur_port;
        rvalid1   = cur_port;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A null read (rd_type 0) returns zero rather than whatever the memory drives.
  assign rd_capture = (lat_rd_type == 2'd0) ? 32'h0 : mem_data_out;

  // Request latch, arbitration history and per-port read results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;  // port 0 wins the first tie
      cur_port    <= 1'b0;
      lat_we      <= 1'b0;
      lat_rd_type <= 2'd0;
      lat_addr    <= 32'h0;
      lat_wdata   <= 32'h0;
      rdata0      <= 32'h0;
      rdata1      <= 32'h0;
    end else begin
      if (accept) begin
        last_grant  <= win_port;
        cur_port    <= win_port;
        lat_we      <= win_port ? we1      : we0;
        lat_rd_type <= win_port ? rd_type1 : rd_type0;
        lat_addr    <= win_port ? addr1    : addr0;
        lat_wdata   <= win_port ? wdata1   : wdata0;
      end
      // Reads capture at the edge that ends ACCESS; writes leave rdata untouched.
      if (state == ACCESS && !lat_we) begin
        if (cur_port) begin
          rdata1 <= rd_capture;
        end else begin
          rdata0 <= rd_capture;
        end
      end
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have these ports, as name, direction, width and meaning:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req0 / req1  in  1  access request from port 0 (CPU load/store) or port 1 (debug/DMA).
- we0 / we1  in  1  1 = word write, 0 = read.
- rd_type0 / rd_type1  in  2  read type: 1 = word, 2 = signed half, 3 = unsigned half, 0 = none.
- addr0 / addr1  in  32  byte address.
- wdata0 / wdata1  in  32  write data, big-endian.
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, inputs latched.
- rvalid0 / rvalid1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  32  read result; valid while rvalid is high.
- mem_address  out  32  to data memory.
- mem_write_data  out  32  to data memory.
- mem_write  out  1  to data memory.
- mem_read  out  2  to data memory, same encoding as rd_type.
- mem_data_out  in  32  combinational read data from data memory.
REQ-002 Parameters: none.

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS and DONE, encoded in a 2-bit register.
REQ-004 IDLE: with any req high, the block SHALL at the next edge latch the winner's we, rd_type, addr and wdata, record the winner in cur_port, and go to ACCESS; with no req it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin:
- a single requester wins;
- if both request, the port other than last_grant wins;
- last_grant SHALL update on each acceptance.
REQ-006 gnt of cur_port SHALL be high for exactly the ACCESS cycle; every other gnt SHALL be low.
REQ-007 ACCESS, write: mem_address and mem_write_data SHALL come from the latched values and mem_write SHALL be 1, so the memory commits at the ACCESS-ending edge; mem_read SHALL be 0.
REQ-008 ACCESS, read with rd_type != 0: mem_read SHALL equal the latched rd_type, mem_write SHALL be 0, and mem_data_out SHALL be captured into rdata of cur_port at the ACCESS-ending edge.
REQ-009 ACCESS, read with rd_type = 0: memory outputs SHALL stay idle and rdata SHALL be captured as 32'h0.
REQ-010 ACCESS SHALL always last one cycle and then go to DONE.
REQ-011 DONE: rvalid of cur_port SHALL be 1 for one cycle, for reads and writes alike; the next state SHALL be IDLE.
REQ-012 rdata SHALL hold its value until that port's next read completes; writes SHALL leave rdata unchanged.
REQ-013 Outside ACCESS: mem_write = 0, mem_read = 0, mem_address = 0 and mem_write_data = 0.
REQ-014 Timing: request sampled in IDLE at edge N, gnt during cycle N+1, rvalid during cycle N+2, earliest next acceptance at edge N+3; throughput SHALL be one access per 3 cycles.
REQ-015 A requester SHALL hold req and its inputs until gnt. A req still high in the DONE cycle SHALL be a new request evaluated in the following IDLE cycle.
REQ-016 Req changes during ACCESS or DONE SHALL NOT affect the access in flight.
REQ-017 No alignment checks SHALL be made; addr SHALL pass through unmodified.

Reset
REQ-018 While rst_n = 0, the block SHALL immediately, without waiting for clk:
- set state to IDLE and last_grant to 1, so port 0 wins the first tie;
- clear cur_port;
- drive every gnt, rvalid, rdata, mem_* output and latched register to 0.
REQ-019 Reset asserted during ACCESS SHALL drop mem_write at once. The aborted access SHALL produce no rvalid, and after release no gnt or rvalid SHALL occur until a new req.

Verification
REQ-020 Single write: req0 = 1, we0 = 1, addr0 = 8, wdata0 = 32'hDEADBEEF -> gnt0 in cycle N+1 with mem_write = 1 and mem_address = 8, rvalid0 in cycle N+2; a port-1 word read of addr 8 then returns rdata1 = 32'hDEADBEEF.
REQ-021 Half reads: memory bytes 0..3 = 22 72 F0 04 (hex), rd_type0 = 3, addr0 = 0 -> rdata0 = 32'h00002272; rd_type0 = 1 -> rdata0 = 32'h2272F004.
REQ-022 Contention: req0 and req1 both held from reset -> grants in order port 0, port 1, port 0, port 1, one every 3 cycles; no cycle has gnt0 and gnt1 both high.
REQ-023 Null read: we1 = 0, rd_type1 = 0 -> mem_read and mem_write stay 0 throughout, rvalid1 pulses, rdata1 = 0.
REQ-024 Reset mid-access: drop rst_n during the ACCESS cycle of a write of 32'h12345678 to addr 4 -> mem_write falls within that cycle, no rvalid; after release, state is IDLE and outputs are 0.
